// File: rtl/ram32x1d_bist_pkg.sv
// Shared types and the March C- element table for the RAM32X1D BIST sequencer.
package ram32x1d_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_M4   = 3'd5,
        ST_M5   = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    typedef struct packed {
        logic down;    // address order 31 -> 0
        logic rd_en;   // compare SPO/DPO this cycle
        logic rd_val;  // expected read value
        logic wr_en;
        logic wr_val;
    } elem_t;

    localparam logic [4:0] ADDR_LO = 5'd0;
    localparam logic [4:0] ADDR_HI = 5'd31;

    // M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0)
    localparam elem_t [0:5] ELEM_TBL = '{
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
    };

    // IDLE and DONE map to an all-zero element: no read, no write.
    function automatic elem_t elem_of(input state_e s);
        elem_t e;
        e = '0;
        case (s)
            ST_M0:   e = ELEM_TBL[0];
            ST_M1:   e = ELEM_TBL[1];
            ST_M2:   e = ELEM_TBL[2];
            ST_M3:   e = ELEM_TBL[3];
            ST_M4:   e = ELEM_TBL[4];
            ST_M5:   e = ELEM_TBL[5];
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic state_e next_march(input state_e s);
        state_e n;
        n = ST_IDLE;
        case (s)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_DONE;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] first_addr(input elem_t e);
        return e.down ? ADDR_HI : ADDR_LO;
    endfunction

    function automatic logic [4:0] last_addr(input elem_t e);
        return e.down ? ADDR_LO : ADDR_HI;
    endfunction

endpackage

// File: rtl/ram32x1d_bist_chk.sv
// Read-data compare for both RAM ports, saturating mismatch counter and
// first-failing-address capture.
module ram32x1d_bist_chk #(
    parameter int ERR_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             rd_en_i,
    input  logic             exp_i,
    input  logic             spo_i,
    input  logic             dpo_i,
    input  logic [4:0]       addr_i,
    output logic [ERR_W-1:0] err_count_o,
    output logic [4:0]       fail_addr_o
);

    logic [ERR_W-1:0] r_err;
    logic [4:0]       r_fail;
    logic             r_seen;
    logic             w_mis;

    // SPO/DPO are the asynchronous reads of the old content, valid before the edge.
    assign w_mis = rd_en_i && ((spo_i != exp_i) || (dpo_i != exp_i));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err  <= '0;
            r_fail <= '0;
            r_seen <= 1'b0;
        end else if (clr_i) begin
            r_err  <= '0;
            r_fail <= '0;
            r_seen <= 1'b0;
        end else if (w_mis) begin
            if (!(&r_err)) begin
                r_err <= r_err + 1'b1;
            end
            if (!r_seen) begin
                r_fail <= addr_i;
                r_seen <= 1'b1;
            end
        end
    end

    assign err_count_o = r_err;
    assign fail_addr_o = r_fail;

endmodule

// File: rtl/ram32x1d_bist_ctrl.sv
// March C- sequencer for an external RAM32X1D: one address per cycle, six
// elements of 32 cycles each, read and write sharing a cycle in M1..M4.
module ram32x1d_bist_ctrl
    import ram32x1d_bist_pkg::*;
#(
    parameter int ERR_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [4:0]       fail_addr_o,
    output logic             ram_we_o,
    output logic             ram_d_o,
    output logic [4:0]       ram_a_o,
    output logic [4:0]       ram_dpra_o,
    input  logic             ram_spo_i,
    input  logic             ram_dpo_i
);

    state_e     r_state;
    logic [4:0] r_addr;
    logic       r_we;
    logic       r_d;
    logic       r_busy;
    logic       r_done;

    elem_t            w_elem;
    elem_t            w_next;
    state_e           w_next_state;
    logic             w_start;
    logic             w_last;
    logic [ERR_W-1:0] w_err_count;

    assign w_elem       = elem_of(r_state);
    assign w_next_state = next_march(r_state);
    assign w_next       = elem_of(w_next_state);
    assign w_start      = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last       = (r_addr == last_addr(w_elem));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_d     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_state <= ST_M0;
                        r_addr  <= first_addr(ELEM_TBL[0]);
                        r_we    <= ELEM_TBL[0].wr_en;
                        r_d     <= ELEM_TBL[0].wr_val;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                    if (!w_last) begin
                        r_addr <= w_elem.down ? r_addr - 5'd1 : r_addr + 5'd1;
                    end else begin
                        // The next element's control values are loaded together with its start address.
                        r_state <= w_next_state;
                        r_addr  <= first_addr(w_next);
                        r_we    <= w_next.wr_en;
                        r_d     <= w_next.wr_val;
                        if (w_next_state == ST_DONE) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_d     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    ram32x1d_bist_chk #(
        .ERR_W(ERR_W)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (w_start),
        .rd_en_i    (w_elem.rd_en),
        .exp_i      (w_elem.rd_val),
        .spo_i      (ram_spo_i),
        .dpo_i      (ram_dpo_i),
        .addr_i     (r_addr),
        .err_count_o(w_err_count),
        .fail_addr_o(fail_addr_o)
    );

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign pass_o      = r_done && (w_err_count == '0);
    assign err_count_o = w_err_count;
    assign ram_we_o    = r_we;
    assign ram_d_o     = r_d;
    assign ram_a_o     = r_addr;
    assign ram_dpra_o  = r_addr;

endmodule

// File: tb/tb_ram32x1d_bist_ctrl.sv
// Bench for ram32x1d_bist_ctrl: behavioural RAM32X1D with injectable stuck-at
// faults, expected run results queued at start and compared when done_o rises.
module tb_ram32x1d_bist_ctrl;

    localparam int ERR_W = 6;

    logic             clk_i;
    logic             rst_ni;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic [ERR_W-1:0] err_count_o;
    logic [4:0]       fail_addr_o;
    logic             ram_we_o;
    logic             ram_d_o;
    logic [4:0]       ram_a_o;
    logic [4:0]       ram_dpra_o;
    logic             ram_spo_i;
    logic             ram_dpo_i;

    typedef struct {
        int err;
        int fail;
        int pass;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   fault_mode = 0;  // 0 none, 1 SPO+DPO sa1 @5, 2 DPO sa0 @7, 3 all sa1

    logic mem [32];

    ram32x1d_bist_ctrl #(
        .ERR_W(ERR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .err_count_o(err_count_o),
        .fail_addr_o(fail_addr_o),
        .ram_we_o   (ram_we_o),
        .ram_d_o    (ram_d_o),
        .ram_a_o    (ram_a_o),
        .ram_dpra_o (ram_dpra_o),
        .ram_spo_i  (ram_spo_i),
        .ram_dpo_i  (ram_dpo_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always_ff @(posedge clk_i) begin
        if (ram_we_o) begin
            mem[ram_a_o] <= ram_d_o;
        end
    end

    always_comb begin
        ram_spo_i = mem[ram_a_o];
        ram_dpo_i = mem[ram_dpra_o];
        if (fault_mode == 3) begin
            ram_spo_i = 1'b1;
            ram_dpo_i = 1'b1;
        end
        if (fault_mode == 1 && ram_a_o == 5'd5)    ram_spo_i = 1'b1;
        if (fault_mode == 1 && ram_dpra_o == 5'd5) ram_dpo_i = 1'b1;
        if (fault_mode == 2 && ram_dpra_o == 5'd7) ram_dpo_i = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic push_exp(input int e_err, input int e_fail, input int e_pass);
        exp_t e;
        e.err  = e_err;
        e.fail = e_fail;
        e.pass = e_pass;
        sb_q.push_back(e);
    endtask

    // Called on the negedge following the accepting edge; returns on the negedge where done_o is seen.
    task automatic run_and_check(input string tag);
        int   cyc;
        int   nbusy;
        int   nwe;
        int   nd1;
        int   nbad_a;
        int   ndpra;
        int   el;
        int   ix;
        int   ea;
        exp_t e;
        cyc = 0; nbusy = 0; nwe = 0; nd1 = 0; nbad_a = 0; ndpra = 0;
        while (done_o !== 1'b1 && cyc < 400) begin
            if (busy_o === 1'b1) begin
                el = nbusy / 32;
                ix = nbusy % 32;
                ea = (el == 3 || el == 4) ? 31 - ix : ix;
                if (int'(ram_a_o) != ea) nbad_a++;
                if (ram_dpra_o !== ram_a_o) ndpra++;
                if (ram_we_o === 1'b1) begin
                    nwe++;
                    if (ram_d_o === 1'b1) nd1++;
                end
                nbusy++;
            end
            @(negedge clk_i);
            cyc++;
        end
        check({tag, " done_reached"}, 32'(done_o), 32'd1);
        check({tag, " busy_cycles"}, nbusy, 192);
        check({tag, " we_cycles"}, nwe, 160);
        check({tag, " write1_cycles"}, nd1, 64);
        check({tag, " addr_seq_errs"}, nbad_a, 0);
        check({tag, " dpra_neq_a"}, ndpra, 0);
        check({tag, " busy_at_done"}, 32'(busy_o), 32'd0);
        check({tag, " we_at_done"}, 32'(ram_we_o), 32'd0);
        check({tag, " sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, " err_count"}, 32'(err_count_o), e.err);
            check({tag, " fail_addr"}, 32'(fail_addr_o), e.fail);
            check({tag, " pass"}, 32'(pass_o), e.pass);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    initial begin
        int nwe_rst;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        #2;
        check("rst busy", 32'(busy_o), 0);
        check("rst done", 32'(done_o), 0);
        check("rst pass", 32'(pass_o), 0);
        check("rst we", 32'(ram_we_o), 0);
        check("rst d", 32'(ram_d_o), 0);
        check("rst a", 32'(ram_a_o), 0);
        check("rst err", 32'(err_count_o), 0);
        check("rst fail", 32'(fail_addr_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        fault_mode = 0;
        push_exp(0, 0, 1);
        pulse_start();
        run_and_check("clean");
        repeat (3) @(negedge clk_i);
        check("clean done_held", 32'(done_o), 1);
        check("clean pass_held", 32'(pass_o), 1);

        fault_mode = 1;
        push_exp(3, 5, 0);
        pulse_start();
        run_and_check("sa1_a5");

        fault_mode = 2;
        push_exp(2, 7, 0);
        pulse_start();
        run_and_check("dpo_sa0_a7");

        fault_mode = 3;
        push_exp(63, 0, 0);
        pulse_start();
        run_and_check("all_sa1");

        // start_i held high for the whole run: no restart while busy, restart on the first DONE edge.
        fault_mode = 0;
        push_exp(0, 0, 1);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        run_and_check("held_start");
        @(posedge clk_i);
        #1;
        check("restart done_drop", 32'(done_o), 0);
        check("restart busy", 32'(busy_o), 1);
        check("restart a", 32'(ram_a_o), 0);
        check("restart we", 32'(ram_we_o), 1);
        check("restart err_clr", 32'(err_count_o), 0);
        @(negedge clk_i);
        start_i = 1'b0;

        // Restarted run is now in cycle 0; cycle 70 lies in M2 at address 6.
        repeat (70) @(posedge clk_i);
        #2;
        check("m2 a", 32'(ram_a_o), 6);
        check("m2 we", 32'(ram_we_o), 1);
        check("m2 d", 32'(ram_d_o), 0);
        rst_ni = 1'b0;
        #1;
        check("abort busy", 32'(busy_o), 0);
        check("abort done", 32'(done_o), 0);
        check("abort pass", 32'(pass_o), 0);
        check("abort we", 32'(ram_we_o), 0);
        check("abort a", 32'(ram_a_o), 0);
        check("abort err", 32'(err_count_o), 0);
        nwe_rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (ram_we_o !== 1'b0) nwe_rst++;
        end
        check("abort we_pulses", nwe_rst, 0);
        rst_ni = 1'b1;

        push_exp(0, 0, 1);
        pulse_start();
        run_and_check("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
